// File: rtl/cdc_pulse_handshake_controller_if.sv
// Handshake bundle between a pulse source and the toggle-based CDC sequencer.
// COUNT_WIDTH must match the controller instance.
interface cdc_pulse_handshake_controller_if #(
    parameter int unsigned COUNT_WIDTH = 4
);
    logic                   enable;
    logic                   pulse_in;
    logic                   ack_sync;
    logic                   clear_flags;
    logic                   req_toggle;
    logic                   busy;
    logic [COUNT_WIDTH-1:0] pending;
    logic                   overflow;
    logic                   timeout;

    modport master (
        output enable, pulse_in, ack_sync, clear_flags,
        input  req_toggle, busy, pending, overflow, timeout
    );

    modport slave (
        input  enable, pulse_in, ack_sync, clear_flags,
        output req_toggle, busy, pending, overflow, timeout
    );
endinterface

// File: rtl/cdc_pulse_handshake_controller.sv
// Source-domain sequencer for toggle-based pulse CDC: queues events, launches one request
// toggle per event and waits for the matching ack toggle before launching the next.
module cdc_pulse_handshake_controller #(
    parameter int unsigned AT_POSEDGE_RST = 1,
    parameter int unsigned COUNT_WIDTH    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    cdc_pulse_handshake_controller_if.slave    hs
);

    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT_CYCLES);
    localparam logic [TmoW-1:0] TmoLast = TmoW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [COUNT_WIDTH-1:0] PendMax = '1;

    typedef enum logic [0:0] {StIdle, StWaitAck} state_e;

    state_e                 state_q;
    logic                   req_toggle_q;
    logic [COUNT_WIDTH-1:0] pending_q;
    logic [COUNT_WIDTH-1:0] pending_d;
    logic                   overflow_q;
    logic                   timeout_q;
    logic [TmoW-1:0]        tmo_cnt_q;

    logic rst_act;
    logic launch;
    logic from_queue;
    logic accept_in;
    logic drop;
    logic tmo_hit;

    // Polarity select only; this block is always built with an active-high reset.
    assign rst_act = (AT_POSEDGE_RST != 0) ? rst : ~rst;

    assign launch     = (state_q == StIdle) && ((pending_q != '0) || hs.pulse_in);
    assign from_queue = (state_q == StIdle) && (pending_q != '0);
    // A pulse arriving in IDLE with an empty queue bypasses the counter entirely.
    assign accept_in  = hs.pulse_in && !((state_q == StIdle) && (pending_q == '0));
    assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (state_q == StWaitAck) &&
                        (hs.ack_sync != req_toggle_q) && (tmo_cnt_q == TmoLast);

    always_comb begin
        pending_d = pending_q;
        drop      = 1'b0;
        if (accept_in && !from_queue) begin
            if (pending_q == PendMax) begin
                drop = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (!accept_in && from_queue) begin
            pending_d = pending_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_act) begin
        if (rst_act) begin
            state_q      <= StIdle;
            req_toggle_q <= 1'b0;
            pending_q    <= '0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
            tmo_cnt_q    <= '0;
        end else if (hs.enable) begin
            pending_q  <= pending_d;
            // Set wins over clear so an event in the clearing cycle is never hidden.
            overflow_q <= (overflow_q & ~hs.clear_flags) | drop;
            timeout_q  <= (timeout_q & ~hs.clear_flags) | tmo_hit;
            unique case (state_q)
                StIdle: begin
                    if (launch) begin
                        req_toggle_q <= ~req_toggle_q;
                        state_q      <= StWaitAck;
                        tmo_cnt_q    <= '0;
                    end
                end
                StWaitAck: begin
                    if (hs.ack_sync == req_toggle_q) begin
                        state_q <= StIdle;
                    end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt_q != TmoMax)) begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign hs.req_toggle = req_toggle_q;
    assign hs.pending    = pending_q;
    assign hs.overflow   = overflow_q;
    assign hs.timeout    = timeout_q;
    assign hs.busy       = (state_q == StWaitAck) | (pending_q != '0);

endmodule

// File: tb/tb_cdc_pulse_handshake_controller.sv
// Bench for the pulse CDC sequencer: a looped-back destination model drives ack_sync and a
// scoreboard pairs every accepted event with one observed req_toggle flip.
module tb_cdc_pulse_handshake_controller;

    localparam int unsigned CW  = 3;
    localparam int unsigned TMO = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cdc_pulse_handshake_controller_if #(.COUNT_WIDTH(CW)) hs ();

    cdc_pulse_handshake_controller #(
        .AT_POSEDGE_RST (1),
        .COUNT_WIDTH    (CW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hs  (hs.slave)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   flips   = 0;
    int   pend_peak;
    bit   ack_hold;
    int   ack_delay;
    logic exp_level;
    logic sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (int'(hs.pending) > pend_peak) pend_peak = int'(hs.pending);
    endtask

    task automatic push_exp();
        exp_level = ~exp_level;
        sb.push_back(exp_level);
    endtask

    task automatic pulse();
        hs.pulse_in = 1'b1;
        step();
        hs.pulse_in = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && hs.busy; i++) step();
        check_eq(tag, hs.busy, 0);
    endtask

    // Destination model: echoes req_toggle back on ack_sync ack_delay cycles after a change.
    initial begin
        int cnt;
        cnt = 0;
        hs.ack_sync = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                hs.ack_sync = 1'b0;
                cnt = 0;
            end else if (!ack_hold && hs.ack_sync != hs.req_toggle) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    hs.ack_sync = hs.req_toggle;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Flip monitor: each req_toggle edge must match the oldest expected launch.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev = hs.req_toggle;
            end else if (hs.req_toggle != prev) begin
                prev = hs.req_toggle;
                flips++;
                if (sb.size() == 0) check_eq("sb_unexpected_flip", sb.size(), 1);
                else check_eq("sb_req_level", hs.req_toggle, sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        int f0;
        exp_level      = 1'b0;
        pend_peak      = 0;
        rst            = 1'b1;
        hs.enable      = 1'b1;
        hs.pulse_in    = 1'b0;
        hs.clear_flags = 1'b0;
        ack_hold       = 1'b0;
        ack_delay      = 4;
        step();
        step();
        check_eq("rst_req", hs.req_toggle, 0);
        check_eq("rst_busy", hs.busy, 0);
        check_eq("rst_pending", hs.pending, 0);
        check_eq("rst_overflow", hs.overflow, 0);
        check_eq("rst_timeout", hs.timeout, 0);
        rst = 1'b0;
        step();

        // Single event: flip one cycle after the pulse, busy for the ack round trip.
        push_exp();
        pulse();
        check_eq("t1_req_latency", hs.req_toggle, 1);
        check_eq("t1_pending", hs.pending, 0);
        busy_cycles = 0;
        for (int i = 0; i < 20 && hs.busy; i++) begin
            busy_cycles++;
            step();
        end
        check_eq("t1_busy_cycles", busy_cycles, 4);

        // Five back-to-back events.
        f0 = flips;
        pend_peak = 0;
        for (int i = 0; i < 5; i++) begin
            push_exp();
            hs.pulse_in = 1'b1;
            step();
        end
        hs.pulse_in = 1'b0;
        drain("t2_drain");
        check_eq("t2_flips", flips - f0, 5);
        check_eq("t2_pending_peak", pend_peak, 4);
        check_eq("t2_sb_empty", sb.size(), 0);

        // Overflow on a full queue, clear, and set-over-clear.
        ack_hold = 1'b1;
        push_exp();
        pulse();
        for (int i = 0; i < 8; i++) begin
            if (i < 7) push_exp();
            pulse();
        end
        check_eq("t3_pending_full", hs.pending, 7);
        check_eq("t3_overflow_set", hs.overflow, 1);
        hs.clear_flags = 1'b1;
        step();
        hs.clear_flags = 1'b0;
        check_eq("t3_overflow_clr", hs.overflow, 0);
        hs.clear_flags = 1'b1;
        hs.pulse_in    = 1'b1;
        step();
        hs.clear_flags = 1'b0;
        hs.pulse_in    = 1'b0;
        check_eq("t3_overflow_set_wins", hs.overflow, 1);
        check_eq("t3_pending_hold", hs.pending, 7);
        ack_delay = 2;
        ack_hold  = 1'b0;
        drain("t3_drain");
        check_eq("t3_pending_empty", hs.pending, 0);
        check_eq("t3_sb_empty", sb.size(), 0);
        hs.clear_flags = 1'b1;
        step();
        hs.clear_flags = 1'b0;
        check_eq("t3_flags_clr_ovf", hs.overflow, 0);
        check_eq("t3_flags_clr_tmo", hs.timeout, 0);

        // Timeout exactly TMO cycles after launch, sticky across a late ack.
        ack_hold = 1'b1;
        push_exp();
        pulse();
        repeat (7) step();
        check_eq("t4_timeout_early", hs.timeout, 0);
        step();
        check_eq("t4_timeout_set", hs.timeout, 1);
        check_eq("t4_still_waiting", hs.busy, 1);
        ack_delay = 1;
        ack_hold  = 1'b0;
        drain("t4_late_ack");
        check_eq("t4_timeout_sticky", hs.timeout, 1);
        hs.clear_flags = 1'b1;
        step();
        hs.clear_flags = 1'b0;
        check_eq("t4_timeout_clr", hs.timeout, 0);

        // enable=0 freezes everything; the ack is taken once enable returns.
        ack_hold = 1'b1;
        push_exp();
        pulse();
        hs.enable   = 1'b0;
        hs.pulse_in = 1'b1;
        ack_delay   = 1;
        ack_hold    = 1'b0;
        step();
        hs.pulse_in = 1'b0;
        step();
        step();
        check_eq("t5_req_frozen", hs.req_toggle, exp_level);
        check_eq("t5_busy_frozen", hs.busy, 1);
        check_eq("t5_pending_frozen", hs.pending, 0);
        hs.enable = 1'b1;
        step();
        check_eq("t5_ack_seen", hs.busy, 0);
        check_eq("t5_pending_after", hs.pending, 0);

        // Asynchronous reset in WAIT_ACK with two queued events.
        ack_hold = 1'b1;
        push_exp();
        pulse();
        pulse();
        pulse();
        check_eq("t6_pending_pre", hs.pending, 2);
        #3;
        rst = 1'b1;
        #1;
        check_eq("t6_async_req", hs.req_toggle, 0);
        check_eq("t6_async_busy", hs.busy, 0);
        check_eq("t6_async_pending", hs.pending, 0);
        check_eq("t6_async_overflow", hs.overflow, 0);
        check_eq("t6_async_timeout", hs.timeout, 0);
        sb.delete();
        exp_level = 1'b0;
        step();
        step();
        rst      = 1'b0;
        ack_hold = 1'b0;
        ack_delay = 2;
        step();

        // Normal operation resumes from a clean state.
        push_exp();
        pulse();
        check_eq("t7_req_after_rst", hs.req_toggle, 1);
        drain("t7_drain");
        repeat (3) step();
        check_eq("sb_left", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
